voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler.sv | 133 +++++++++++++
 tb/tb_voice_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Sequences NV voice modules once per sample tick, shares one multiplier among them,
// and mixes their outputs into a saturated 24-bit sample.
module voice_scheduler #(
  parameter int NV      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic [NV-1:0]    voice_enable,
  output logic [NV-1:0]    voice_start,
  input  logic [NV-1:0]    voice_finish,
  input  logic [NV*32-1:0] voice_mult_a,
  input  logic [NV*32-1:0] voice_mult_b,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic [NV*24-1:0] voice_wave,
  output logic [23:0]      mix_out,
  output logic             mix_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  input  logic             clear_err
);
  localparam int IW = $clog2(NV);
  localparam int AW = 24 + IW;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST   = IW'(NV - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t           state, nstate;
  logic [IW-1:0]    idx;
  logic [AW-1:0]    acc;
  logic [WW-1:0]    wd;
  logic [NV-1:0]    en_q;
  logic             fin_hit, to_hit;
  logic [AW-1:0]    wave_ext;
  logic [23:0]      sat;

  logic [NV-1:0][31:0] ma_v, mb_v;
  logic [NV-1:0][23:0] wv_v;

  assign ma_v = voice_mult_a;
  assign mb_v = voice_mult_b;
  assign wv_v = voice_wave;
  assign busy = (state != S_IDLE);
  assign wave_ext = {{(AW-24){wv_v[idx][23]}}, wv_v[idx]};

  // Top bits all equal means the sum still fits in 24 bits.
  always_comb begin
    sat = acc[23:0];
    if (!(acc[AW-1:23] == '0 || acc[AW-1:23] == '1))
      sat = acc[AW-1] ? 24'h800000 : 24'h7FFFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate      = state;
    fin_hit     = 1'b0;
    to_hit      = 1'b0;
    voice_start = '0;
    mult_a      = '0;
    mult_b      = '0;
    case (state)
      S_IDLE:  if (sample_tick) nstate = S_START;
      S_START: begin
        mult_a = ma_v[idx];
        mult_b = mb_v[idx];
        if (en_q[idx]) begin
          voice_start[idx] = 1'b1;
          nstate           = S_WAIT;
        end else begin
          nstate = S_NEXT;
        end
      end
      S_WAIT: begin
        mult_a = ma_v[idx];
        mult_b = mb_v[idx];
        if (voice_finish[idx]) begin
          fin_hit = 1'b1;
          nstate  = S_NEXT;
        end else if (wd == WD_MAX) begin
          to_hit = 1'b1;
          nstate = S_NEXT;
        end
      end
      S_NEXT:  nstate = (idx == LAST) ? S_DONE : S_START;
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      acc         <= '0;
      wd          <= '0;
      en_q        <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        S_IDLE: if (sample_tick) begin
          idx  <= '0;
          acc  <= '0;
          en_q <= voice_enable;
        end
        S_WAIT: if (fin_hit) acc <= acc + wave_ext;
        S_NEXT: if (idx != LAST) idx <= idx + 1'b1;
        S_DONE: begin
          mix_out   <= sat;
          mix_valid <= 1'b1;
        end
        default: ;
      endcase
      wd <= (state == S_WAIT && nstate == S_WAIT) ? wd + 1'b1 : '0;
      // Set beats clear when both land in the same cycle.
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      else if (clear_err)                 overrun <= 1'b0;
      if (to_hit)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: behavioural voices answer start pulses after 5 cycles.
module tb_voice_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [3:0]  voice_enable = '0;
  logic [3:0]  voice_start;
  logic [3:0]  fin_model = '0;
  logic [3:0]  fin_extra = '0;
  logic [3:0]  voice_finish;
  logic [3:0][31:0] opa, opb;
  logic [3:0][23:0] wave;
  logic [31:0] mult_a, mult_b;
  logic [23:0] mix_out;
  logic        mix_valid, busy, overrun, timeout_err;
  logic        clear_err = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int cnt [4];
  bit hang [4];

  assign voice_finish = fin_model | fin_extra;

  voice_scheduler #(.NV(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .voice_enable(voice_enable), .voice_start(voice_start),
    .voice_finish(voice_finish), .voice_mult_a(opa), .voice_mult_b(opb),
    .mult_a(mult_a), .mult_b(mult_b), .voice_wave(wave),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Voice i pulses finish in the 5th cycle after its start pulse unless hung.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      fin_model[i] = 1'b0;
      if (!rst_n) cnt[i] = 0;
      else begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0 && !hang[i]) fin_model[i] = 1'b1;
        end
        if (voice_start[i]) cnt[i] = 5;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample: tick, optional extra tick (with optional clear_err) at cycle extra_at.
  task automatic run(input logic [3:0] en, input int lat_exp, input logic [23:0] mix_exp,
                     input int ord_exp, input int extra_at, input bit clr, input string tag);
    int lat = -1, nvalid = 0, ord = 0, cur = 0, rem = 0, muxerr = 0;
    logic [23:0] mo = 'x;
    @(negedge clk);
    voice_enable = en;
    sample_tick  = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mix_valid) begin
        nvalid++;
        if (lat < 0) begin lat = c; mo = mix_out; end
      end
      if (voice_start != '0) begin
        for (int i = 0; i < 4; i++)
          if (voice_start[i]) begin
            ord = ord * 10 + i + 1;
            cur = i;
            rem = hang[i] ? 16 : 5;
            if (mult_a !== opa[i] || mult_b !== opb[i]) muxerr++;
          end
      end else if (rem > 0) begin
        rem--;
        if (mult_a !== opa[cur] || mult_b !== opb[cur]) muxerr++;
      end else if (!busy && (mult_a !== 32'd0 || mult_b !== 32'd0)) muxerr++;
      sample_tick = (c == extra_at);
      clear_err   = (c == extra_at) && clr;
    end
    sample_tick = 1'b0;
    clear_err   = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, "_mix"}, {8'd0, mo}, {8'd0, mix_exp});
    chk({tag, "_nvalid"}, 32'(nvalid), 32'd1);
    chk({tag, "_order"}, 32'(ord), 32'(ord_exp));
    chk({tag, "_mux"}, 32'(muxerr), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      opa[i] = 32'hA5A5_0000 | 32'(i);
      opb[i] = 32'h5A5A_0000 | 32'(i << 4);
      hang[i] = 1'b0;
      cnt[i]  = 0;
    end
    wave = '0;
    repeat (3) @(negedge clk);
    chk("rst_mix_out", {8'd0, mix_out}, 32'd0);
    chk("rst_mix_valid", {31'd0, mix_valid}, 32'd0);
    chk("rst_start", {28'd0, voice_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mult_a", mult_a, 32'd0);
    chk("rst_mult_b", mult_b, 32'd0);
    chk("rst_flags", {30'd0, overrun, timeout_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wave = {24'd7, 24'd200, -24'sd50, 24'd100};
    run(4'hF, 30, 24'd257, 1234, 0, 1'b0, "basic");
    chk("basic_flags", {30'd0, overrun, timeout_err}, 32'd0);

    wave = {4{24'h7FFFFF}};
    run(4'hF, 30, 24'h7FFFFF, 1234, 0, 1'b0, "sat_pos");
    wave = {4{24'h800000}};
    run(4'hF, 30, 24'h800000, 1234, 0, 1'b0, "sat_neg");

    wave = {24'd9, -24'sd3000, 24'd5, 24'd1000};
    fin_extra = 4'b1010;
    run(4'b0101, 20, 24'hFFF830, 13, 0, 1'b0, "en0101");
    fin_extra = 4'b0000;

    wave = {24'd40, 24'd30, 24'd20, 24'd10};
    hang[1] = 1'b1;
    run(4'hF, 41, 24'd80, 1234, 0, 1'b0, "timeout");
    hang[1] = 1'b0;
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    pulse_clear();
    chk("timeout_err_clr", {31'd0, timeout_err}, 32'd0);

    wave = {24'd4, 24'd3, 24'd2, 24'd1};
    run(4'hF, 30, 24'd10, 1234, 3, 1'b0, "overrun");
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    pulse_clear();
    chk("overrun_clr", {31'd0, overrun}, 32'd0);

    // Reset while voice 0 waits, after provoking an overrun.
    @(negedge clk); voice_enable = 4'hF; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_start", {28'd0, voice_start}, 32'd0);
    chk("midrst_mix_out", {8'd0, mix_out}, 32'd0);
    chk("midrst_mult", mult_a | mult_b, 32'd0);
    chk("midrst_flags", {30'd0, overrun, timeout_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_start", {28'd0, voice_start}, 32'd0);
    chk("post_rst_valid", {31'd0, mix_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    run(4'hF, 30, 24'd10, 1234, 0, 1'b0, "after_rst");

    // All disabled; tick plus clear_err land in the DONE cycle.
    run(4'h0, 10, 24'd0, 0, 9, 1'b1, "all_off");
    chk("done_tick_overrun", {31'd0, overrun}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
